op_arbiter: RTL
===============

OP_ARBITER -- requirements
Module: op_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter OP_W, default 3, opcode width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles waited on the unit per phase (ISSUE, WAIT_Z).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req0_a / req1_a  in  DATA_W  operand A of requester 0/1.
REQ-007 SHALL have ports req0_b / req1_b  in  DATA_W  operand B of requester 0/1.
REQ-008 SHALL have ports req0_op / req1_op  in  OP_W  opcode of requester 0/1.
REQ-009 SHALL have ports req0_stable / req1_stable  in  1  request valid, held by requester until its ack.
REQ-010 SHALL have ports req0_ack / req1_ack  out  1  one-cycle pulse: request captured.
REQ-011 SHALL have ports req0_z / req1_z  out  DATA_W  result to requester 0/1.
REQ-012 SHALL have ports req0_z_stable / req1_z_stable  out  1  result valid.
REQ-013 SHALL have ports req0_z_ack / req1_z_ack  in  1  requester accepted result.
REQ-014 SHALL have ports unit_a, unit_b  out  DATA_W  and unit_op  out  OP_W  operands/opcode to shared unit.
REQ-015 SHALL have port unit_stable  out  1  operands valid to unit; port unit_ack  in  1  unit took operands.
REQ-016 SHALL have port unit_z  in  DATA_W  and unit_z_stable  in  1  unit result valid, held until unit_z_ack.
REQ-017 SHALL have port unit_z_ack  out  1  one-cycle pulse: unit result captured.
REQ-018 SHALL have ports busy  out  1  (state != IDLE), grant_id  out  1  (current/last owner), timeout_err  out  1  (sticky).

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT_Z, RETURN; all outputs registered.
REQ-020 IDLE: if any reqN_stable, SHALL grant per round-robin, capture a/b/op into internal registers, pulse reqN_ack one cycle, set grant_id, go ISSUE next cycle.
REQ-021 Round-robin: both stable in same cycle SHALL grant requester != last completed grant; single requester SHALL be granted regardless of pointer.
REQ-022 ISSUE: SHALL drive unit_a/b/op from captured registers with unit_stable=1; on unit_ack SHALL drop unit_stable and go WAIT_Z.
REQ-023 WAIT_Z: on unit_z_stable SHALL capture unit_z, pulse unit_z_ack one cycle, go RETURN.
REQ-024 unit_ack and unit_z_stable high in same ISSUE cycle: SHALL only take ack; z handled in WAIT_Z next cycle (unit holds z_stable).
REQ-025 RETURN: SHALL drive reqN_z = captured result, reqN_z_stable=1 for granted N only; on reqN_z_ack SHALL clear z_stable, update round-robin pointer, go IDLE.
REQ-026 Minimum latency reqN_stable to reqN_z_stable SHALL be 4 cycles with unit answering in zero cycles.
REQ-027 No request SHALL be acked outside IDLE; stable held by the other requester SHALL wait.
REQ-028 Requester dropping stable before ack SHALL not be granted; no partial capture.
REQ-029 Per-phase cycle counter SHALL reset on entering ISSUE and WAIT_Z; reaching TIMEOUT SHALL set timeout_err, return z = 0 via RETURN, drop unit_stable.
REQ-030 timeout_err SHALL stay 1 until reset; arbitration SHALL continue normally afterward.
REQ-031 Opcode SHALL be passed through unmodified; arbiter SHALL not interpret it.
REQ-032 reqN_z SHALL hold last returned value after RETURN until next RETURN to the same requester.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, all outputs 0, internal operand/result registers 0, counter 0, timeout_err 0.
REQ-034 Round-robin pointer SHALL reset to last_grant=1 so requester 0 wins the first contention.
REQ-035 Reset mid-operation SHALL abandon the transaction without any ack or z_stable pulse; operation restarts only on fresh request.

Verification
REQ-036 Single: req0 a=3F800000,b=40000000,op=0; unit returns 40400000 after 2 cycles -> req0_ack 1 cycle, unit_a/b match, req0_z=40400000, req1 outputs 0.
REQ-037 Contention: both stable after reset -> req0 served first, req1 acked in IDLE following req0_z_ack; repeat -> order alternates 0,1,0,1.
REQ-038 Back-pressure: hold req0_z_ack low 10 cycles -> req0_z_stable held, req1 not acked, busy=1 throughout.
REQ-039 Timeout: unit_ack never asserted -> after TIMEOUT cycles timeout_err=1, req0_z=0 with z_stable; next request completes normally, timeout_err stays 1.
REQ-040 Reset in WAIT_Z: assert rst_n low -> busy=0, unit_stable=0, no req0_z_stable; after release, new req1 granted first-contention rules.
REQ-041 Same-cycle unit_ack+unit_z_stable in ISSUE -> unit_z_ack pulses exactly one cycle later, result delivered once.

Source files
------------

// File: rtl/op_arbiter.sv
// Two-requester round-robin front end for a single shared operation unit.
// Each transaction runs IDLE -> ISSUE -> WAIT_Z -> RETURN. Every output is registered.
module op_arbiter #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req0_stable,
    output logic              req0_ack,
    output logic [DATA_W-1:0] req0_z,
    output logic              req0_z_stable,
    input  logic              req0_z_ack,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    input  logic              req1_stable,
    output logic              req1_ack,
    output logic [DATA_W-1:0] req1_z,
    output logic              req1_z_stable,
    input  logic              req1_z_ack,
    output logic [DATA_W-1:0] unit_a,
    output logic [DATA_W-1:0] unit_b,
    output logic [OP_W-1:0]   unit_op,
    output logic              unit_stable,
    input  logic              unit_ack,
    input  logic [DATA_W-1:0] unit_z,
    input  logic              unit_z_stable,
    output logic              unit_z_ack,
    output logic              busy,
    output logic              grant_id,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_Z, S_RETURN} state_t;

    state_t            r_state, w_state_next;
    logic [DATA_W-1:0] r_a, r_b, r_result, r_req0_z, r_req1_z;
    logic [OP_W-1:0]   r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last_grant, r_grant_id, r_busy, r_timeout_err;
    logic              r_req0_ack, r_req1_ack, r_req0_z_stable, r_req1_z_stable;
    logic              r_unit_stable, r_unit_z_ack;

    logic [DATA_W-1:0] w_a_next, w_b_next, w_result_next, w_req0_z_next, w_req1_z_next;
    logic [OP_W-1:0]   w_op_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_last_grant_next, w_grant_id_next, w_timeout_err_next;
    logic              w_req0_ack_next, w_req1_ack_next;
    logic              w_req0_z_stable_next, w_req1_z_stable_next;
    logic              w_unit_stable_next, w_unit_z_ack_next;

    logic w_any_req, w_pick1, w_expired, w_ret_stable, w_ret_ack;

    // Contention goes to the requester that did not complete last; a lone requester always wins.
    assign w_any_req    = req0_stable | req1_stable;
    assign w_pick1      = req1_stable & (~req0_stable | ~r_last_grant);
    assign w_expired    = (r_cnt == CNT_LAST);
    assign w_ret_stable = r_grant_id ? r_req1_z_stable : r_req0_z_stable;
    assign w_ret_ack    = r_grant_id ? req1_z_ack : req0_z_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (unit_ack) w_state_next = S_WAIT_Z;
                else if (w_expired) w_state_next = S_RETURN;
            end
            S_WAIT_Z: begin
                if (unit_z_stable || w_expired) w_state_next = S_RETURN;
            end
            S_RETURN: begin
                if (w_ret_stable && w_ret_ack) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_a_next             = r_a;
        w_b_next             = r_b;
        w_op_next            = r_op;
        w_result_next        = r_result;
        w_cnt_next           = r_cnt + CNT_W'(1);
        w_last_grant_next    = r_last_grant;
        w_grant_id_next      = r_grant_id;
        w_timeout_err_next   = r_timeout_err;
        w_req0_ack_next      = 1'b0;
        w_req1_ack_next      = 1'b0;
        w_req0_z_next        = r_req0_z;
        w_req1_z_next        = r_req1_z;
        w_req0_z_stable_next = r_req0_z_stable;
        w_req1_z_stable_next = r_req1_z_stable;
        w_unit_stable_next   = r_unit_stable;
        w_unit_z_ack_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_any_req) begin
                    w_grant_id_next    = w_pick1;
                    w_req0_ack_next    = ~w_pick1;
                    w_req1_ack_next    = w_pick1;
                    w_a_next           = w_pick1 ? req1_a  : req0_a;
                    w_b_next           = w_pick1 ? req1_b  : req0_b;
                    w_op_next          = w_pick1 ? req1_op : req0_op;
                    w_unit_stable_next = 1'b1;
                end
            end
            S_ISSUE: begin
                // A result offered alongside unit_ack is left for WAIT_Z; the unit keeps holding it.
                if (unit_ack) begin
                    w_unit_stable_next = 1'b0;
                    w_cnt_next         = '0;
                end else if (w_expired) begin
                    w_unit_stable_next = 1'b0;
                    w_timeout_err_next = 1'b1;
                    w_result_next      = '0;
                end
            end
            S_WAIT_Z: begin
                if (unit_z_stable) begin
                    w_result_next     = unit_z;
                    w_unit_z_ack_next = 1'b1;
                end else if (w_expired) begin
                    w_timeout_err_next = 1'b1;
                    w_result_next      = '0;
                end
            end
            S_RETURN: begin
                w_cnt_next = '0;
                if (!w_ret_stable) begin
                    if (r_grant_id) begin
                        w_req1_z_next        = r_result;
                        w_req1_z_stable_next = 1'b1;
                    end else begin
                        w_req0_z_next        = r_result;
                        w_req0_z_stable_next = 1'b1;
                    end
                end else if (w_ret_ack) begin
                    w_req0_z_stable_next = 1'b0;
                    w_req1_z_stable_next = 1'b0;
                    w_last_grant_next    = r_grant_id;
                end
            end
            default: w_cnt_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a             <= '0;
            r_b             <= '0;
            r_op            <= '0;
            r_result        <= '0;
            r_cnt           <= '0;
            r_last_grant    <= 1'b1;
            r_grant_id      <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_req0_ack      <= 1'b0;
            r_req1_ack      <= 1'b0;
            r_req0_z        <= '0;
            r_req1_z        <= '0;
            r_req0_z_stable <= 1'b0;
            r_req1_z_stable <= 1'b0;
            r_unit_stable   <= 1'b0;
            r_unit_z_ack    <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_a             <= w_a_next;
            r_b             <= w_b_next;
            r_op            <= w_op_next;
            r_result        <= w_result_next;
            r_cnt           <= w_cnt_next;
            r_last_grant    <= w_last_grant_next;
            r_grant_id      <= w_grant_id_next;
            r_timeout_err   <= w_timeout_err_next;
            r_req0_ack      <= w_req0_ack_next;
            r_req1_ack      <= w_req1_ack_next;
            r_req0_z        <= w_req0_z_next;
            r_req1_z        <= w_req1_z_next;
            r_req0_z_stable <= w_req0_z_stable_next;
            r_req1_z_stable <= w_req1_z_stable_next;
            r_unit_stable   <= w_unit_stable_next;
            r_unit_z_ack    <= w_unit_z_ack_next;
            r_busy          <= (w_state_next != S_IDLE);
        end
    end

    assign req0_ack      = r_req0_ack;
    assign req1_ack      = r_req1_ack;
    assign req0_z        = r_req0_z;
    assign req1_z        = r_req1_z;
    assign req0_z_stable = r_req0_z_stable;
    assign req1_z_stable = r_req1_z_stable;
    assign unit_a        = r_a;
    assign unit_b        = r_b;
    assign unit_op       = r_op;
    assign unit_stable   = r_unit_stable;
    assign unit_z_ack    = r_unit_z_ack;
    assign busy          = r_busy;
    assign grant_id      = r_grant_id;
    assign timeout_err   = r_timeout_err;

endmodule
